// File: rtl/apb4_mst_pkg.sv
// Shared types for the APB4 requester: FSM state encoding and the response record
// carried from the ACCESS phase to the response stream.
package apb4_mst_pkg;

  localparam int MAX_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // rdata is sized for the widest legal bus; narrower buses use the low bits.
  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      tmo;
  } rsp_t;

endpackage

// File: rtl/apb4_mst_tmo.sv
// Saturating wait-state counter; expired_o flags the last ACCESS cycle allowed
// before the requester abandons a slave that never raises pready.
module apb4_mst_tmo
  import apb4_mst_pkg::*;
#(
  parameter int TMO_WIDTH  = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_WIDTH-1:0] LIMIT =
    TMO_WIDTH'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);

  logic [TMO_WIDTH-1:0] count_q;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // A zero cycle budget disables the abort entirely.
  assign expired_o = (TMO_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/apb4_mst.sv
// APB4 requester: turns one valid/ready command into one SETUP/ACCESS transfer and
// returns read data plus error/timeout status on a valid/ready response stream.
module apb4_mst
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tmo_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  state_e state_q, state_d;
  rsp_t   rsp_q, rsp_d;
  logic   tmo_clr, tmo_en, tmo_expired;

  logic                    psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;

  apb4_mst_tmo #(
    .TMO_WIDTH (TMO_WIDTH),
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) state_d = SETUP;
      end
      SETUP: begin
        tmo_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rsp_d.rdata = pwrite_q ? '0 : MAX_DATA_WIDTH'(prdata_i);
          rsp_d.err   = pslverr_i;
          rsp_d.tmo   = 1'b0;
          state_d     = RESP;
        end else if (tmo_expired) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          rsp_d.tmo   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rsp_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      // Bus controls follow the next state so they are flop outputs, not decodes.
      psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q <= (state_d == ACCESS);
      if ((state_q == IDLE) && cmd_valid_i) begin
        pwrite_q <= cmd_write_i;
        paddr_q  <= cmd_addr_i;
        pprot_q  <= cmd_prot_i;
        pwdata_q <= cmd_write_i ? cmd_wdata_i : '0;
        pstrb_q  <= cmd_write_i ? cmd_strb_i  : '0;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE) && !rst_i;

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pprot_o   = pprot_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err_o   = rsp_q.err;
  assign rsp_tmo_o   = rsp_q.tmo;

endmodule

// File: tb/tb_apb4_mst.sv
// Self-checking bench for apb4_mst: directed scenarios plus randomized transfers,
// each predicted from the transfer's wait count, error flag and backpressure.
module tb_apb4_mst;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic [2:0]  cmd_prot_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_tmo_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int checks = 0;
  int errors = 0;

  apb4_mst #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TMO_WIDTH (8),
    .TMO_CYCLES(TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_strb_i (cmd_strb_i),
    .cmd_prot_i (cmd_prot_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .rsp_tmo_o  (rsp_tmo_o),
    .paddr_o    (paddr_o),
    .pprot_o    (pprot_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete transfer. The slave holds pready low for 'waits' ACCESS cycles;
  // the response is held off for 'bp' cycles. Called just after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic slverr, input logic [31:0] rdata, input int bp);
    logic        exp_tmo, exp_err;
    logic [31:0] exp_rdata, exp_wdata;
    logic [3:0]  exp_strb;
    int          n_access;
    exp_tmo   = (TMO != 0) && (waits >= TMO);
    n_access  = exp_tmo ? TMO : waits + 1;
    exp_err   = exp_tmo || slverr;
    exp_rdata = (exp_tmo || wr) ? 32'h0 : rdata;
    exp_wdata = wr ? wdata : 32'h0;
    exp_strb  = wr ? strb : 4'h0;

    #1;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
    cmd_wdata_i = wdata; cmd_strb_i = strb; cmd_prot_i = prot;
    rsp_ready_i = 1'b0; pready_i = 1'($urandom); pslverr_i = 1'($urandom);
    @(negedge clk_i);
    check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("idle_psel", 64'(psel_o), 64'd0);
    @(posedge clk_i);

    #1;
    cmd_valid_i = 1'($urandom); cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
    cmd_write_i = 1'($urandom); pready_i = 1'($urandom);
    @(negedge clk_i);
    check("setup_psel", 64'(psel_o), 64'd1);
    check("setup_penable", 64'(penable_o), 64'd0);
    check("setup_pwrite", 64'(pwrite_o), 64'(wr));
    check("setup_paddr", 64'(paddr_o), 64'(addr));
    check("setup_pwdata", 64'(pwdata_o), 64'(exp_wdata));
    check("setup_pstrb", 64'(pstrb_o), 64'(exp_strb));
    check("setup_pprot", 64'(pprot_o), 64'(prot));
    check("setup_cmd_ready", 64'(cmd_ready_o), 64'd0);
    @(posedge clk_i);

    for (int i = 0; i < n_access; i++) begin
      #1;
      pready_i  = (i == waits);
      prdata_i  = (i == waits) ? rdata : $urandom;
      pslverr_i = (i == waits) ? slverr : 1'($urandom);
      @(negedge clk_i);
      check("access_psel", 64'(psel_o), 64'd1);
      check("access_penable", 64'(penable_o), 64'd1);
      check("access_paddr", 64'(paddr_o), 64'(addr));
      check("access_pwdata", 64'(pwdata_o), 64'(exp_wdata));
      check("access_pstrb", 64'(pstrb_o), 64'(exp_strb));
      check("access_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("access_cmd_ready", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i);
    end

    for (int i = 0; i <= bp; i++) begin
      #1;
      rsp_ready_i = (i == bp);
      pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
      @(negedge clk_i);
      check("resp_valid", 64'(rsp_valid_o), 64'd1);
      check("resp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
      check("resp_err", 64'(rsp_err_o), 64'(exp_err));
      check("resp_tmo", 64'(rsp_tmo_o), 64'(exp_tmo));
      check("resp_psel", 64'(psel_o), 64'd0);
      check("resp_penable", 64'(penable_o), 64'd0);
      check("resp_cmd_ready", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_strb_i = '0; cmd_prot_i = '0; rsp_ready_i = 1'b0;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;

    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_psel", 64'(psel_o), 64'd0);
    check("rst_penable", 64'(penable_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_paddr", 64'(paddr_o), 64'd0);
    check("rst_pwdata", 64'(pwdata_o), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);

    // Zero-wait write, slow read, timeout, slave error, response backpressure.
    xfer(1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
    xfer(1'b0, 32'h0000_0004, 32'hCAFE_F00D, 4'hA, 3'd2, 3, 1'b0, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd1, TMO + 6, 1'b0, 32'h5555_AAAA, 2);
    xfer(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'h3, 3'd5, 0, 1'b1, 32'h0, 0);
    xfer(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'd7, 1, 1'b0, 32'h0BAD_F00D, 5);

    // Reset in the middle of ACCESS: transfer and response are dropped.
    #1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h0000_0030;
    cmd_wdata_i = 32'h7777_8888; cmd_strb_i = 4'hF; cmd_prot_i = 3'd3;
    pready_i = 1'b0;
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_psel_before", 64'(psel_o), 64'd1);
    check("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0; pready_i = 1'b1; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_psel", 64'(psel_o), 64'd0);
    check("mid_rst_penable", 64'(penable_o), 64'd0);
    check("mid_rst_pwrite", 64'(pwrite_o), 64'd0);
    check("mid_rst_paddr", 64'(paddr_o), 64'd0);
    check("mid_rst_pwdata", 64'(pwdata_o), 64'd0);
    check("mid_rst_pstrb", 64'(pstrb_o), 64'd0);
    check("mid_rst_pprot", 64'(pprot_o), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("mid_rst_rsp_err", 64'(rsp_err_o), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("post_rst_psel", 64'(psel_o), 64'd0);
    end
    @(posedge clk_i);

    // Randomized transfers; wait counts straddle the timeout budget.
    for (int n = 0; n < 60; n++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, TMO + 2)), 1'($urandom), $urandom,
           int'($urandom_range(0, 3)));
    end

    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("final_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("final_rsp_valid", 64'(rsp_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
